noc_pkt_sched_2to1: RTL
=======================

Name: noc_pkt_sched_2to1

Overview:
Packet-level weighted round-robin scheduler that shares one 32-bit AXI-stream sample path, with a 128-bit CVITA header on tuser, between two requesters, e.g. a data stream and a per-packet status stream, ahead of a single chdr_framer. Packets are never interleaved. Weights, priority mode and enable come from the block's settings bus. Per-port grant counters are exported for readback.

Parameters:
WIDTH, 32, tdata width
USER_WIDTH, 128, tuser (CVITA header) width
SR_SCHED_BASE, 130, settings base; +0 weight0, +1 weight1, +2 control, +3 counter clear

Ports:
ce_clk  in  1  compute-engine clock
ce_rst_n  in  1  asynchronous active-low reset
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
i0_tdata / i1_tdata  in  WIDTH  requester sample data
i0_tuser / i1_tuser  in  USER_WIDTH  requester header, valid with the first beat
i0_tlast / i1_tlast  in  1  last beat of packet
i0_tvalid / i1_tvalid  in  1  requester valid
i0_tready / i1_tready  out  1  requester ready
o_tdata  out  WIDTH  muxed data
o_tuser  out  USER_WIDTH  muxed header
o_tlast  out  1  muxed last
o_tvalid  out  1  muxed valid
o_tready  in  1  downstream ready
pkt_cnt0 / pkt_cnt1  out  32  packets granted per port, wrapping at 2^32
active_port  out  1  current grant (0/1)
busy  out  1  high while a packet is in flight

Behaviour:
- Registers are written when set_stb is high and set_addr matches.
  - weight0/weight1 use set_data[7:0]. A weight of 0 is treated as 1. Reset value is 1.
  - control: bit0 enable (reset 1), bit1 strict_prio0 (reset 0).
  - A write to base+3 zeroes both counters. That write overrides an increment in the same cycle.
  - New weights take effect at the next credit load only.
- FSM states: IDLE, GRANT0, GRANT1. The grant is registered and the mux is combinational.
  - Output forwarding adds zero latency.
  - ix_tready = (state==GRANTx) & o_tready. The non-granted tready is 0.
  - o_tvalid = granted ix_tvalid. It is 0 in IDLE.
- Beat handshake: a beat transfers when o_tvalid & o_tready.
  - in_pkt is set on a non-last handshake and cleared on the tlast handshake.
  - busy = in_pkt | (handshake this cycle).
- credit register: loaded with max(weight,1) on entry to GRANTx. Decremented on each tlast handshake.
- A decision point is any cycle in which not in_pkt and no handshake is occurring.
- IDLE, enable=1:
  - Both valid: grant the port opposite last_served. last_served resets to 1, so port0 wins first.
  - One valid: grant that port.
  - strict_prio0=1: port0 wins whenever i0_tvalid.
  - The transition takes one cycle, so the first beat is accepted the cycle after the request at the earliest.
- GRANTx, at the tlast handshake:
  - pkt_cntx increments and last_served becomes x.
  - Next state from the inputs sampled in that cycle:
    - enable=0 → IDLE.
    - strict_prio0 and x==1 and i0_tvalid → GRANT0.
    - credit-1>0 → stay in GRANTx.
    - other port valid → GRANTy with a credit load.
    - own port valid → stay in GRANTx and reload credit.
    - otherwise → IDLE.
- GRANTx decision point with own tvalid low:
  - Other port valid → GRANTy with a credit load.
  - Other port not valid → remain in GRANTx.
  - The switch costs one idle cycle.
- Mid-packet the grant never changes, whatever the state of the other valid, the settings or enable.
  - Clearing enable stops new grants only. The current packet completes.
- A single-beat packet (tvalid with tlast on the first beat) counts as one packet and one credit.
- Reset, asynchronous on the ce_rst_n falling edge:
  - state IDLE, both tready 0, o_tvalid 0, counters 0, active_port 0, busy 0.
  - Registers return to their reset values.
  - A packet truncated by reset is dropped. Downstream must be reset together with this block.
  - Deassertion is synchronous to ce_clk.
- o_tdata/o_tuser/o_tlast mirror the granted port even when tvalid is low. They are 0 in IDLE.

Test Plan:
- Weights 1/1, both ports continuously offering 4-beat packets, o_tready=1 → grants alternate P0,P1,P0,P1, each packet exactly 4 contiguous beats, pkt_cnt0=pkt_cnt1=50 after 100 packets.
- weight0=3, weight1=1, both saturated → grant pattern P0,P0,P0,P1 repeating; after 40 packets pkt_cnt0=30, pkt_cnt1=10.
- strict_prio0=1, P1 sends a 16-beat packet with P0 asserting at beat 5 → P1 packet completes uninterrupted, then P0 is granted immediately, with no P1 packet until P0 goes idle.
- Random o_tready backpressure (50%) with mid-packet toggling of i1_tvalid → no beat lost or duplicated, no interleaving; a scoreboard matches per-port sequences and tuser on the first beat.
- enable cleared mid-packet on P0 (beat 2 of 8) → beats 3-8 still delivered, then IDLE with both tready 0; setting enable resumes arbitration.
- ce_rst_n pulsed low mid-packet and counter clear written on the same cycle as a tlast handshake → all outputs immediately at reset values; after the clear, the counter reads 0, not 1.

Source files
------------

// File: rtl/noc_pkt_sched_2to1.sv
// noc_pkt_sched_2to1: packet-level weighted round-robin scheduler sharing one
// AXI-stream sample path (with CVITA header on tuser) between two requesters.
// The grant is registered; the data path is a zero-latency combinational mux.
module noc_pkt_sched_2to1 #(
  parameter int WIDTH         = 32,
  parameter int USER_WIDTH    = 128,
  parameter int SR_SCHED_BASE = 130
) (
  input  logic                  ce_clk,
  input  logic                  ce_rst_n,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  input  logic [WIDTH-1:0]      i0_tdata,
  input  logic [USER_WIDTH-1:0] i0_tuser,
  input  logic                  i0_tlast,
  input  logic                  i0_tvalid,
  output logic                  i0_tready,
  input  logic [WIDTH-1:0]      i1_tdata,
  input  logic [USER_WIDTH-1:0] i1_tuser,
  input  logic                  i1_tlast,
  input  logic                  i1_tvalid,
  output logic                  i1_tready,
  output logic [WIDTH-1:0]      o_tdata,
  output logic [USER_WIDTH-1:0] o_tuser,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic [31:0]           pkt_cnt0,
  output logic [31:0]           pkt_cnt1,
  output logic                  active_port,
  output logic                  busy
);

  localparam logic [7:0] ADDR_WEIGHT0 = 8'(SR_SCHED_BASE);
  localparam logic [7:0] ADDR_WEIGHT1 = 8'(SR_SCHED_BASE + 1);
  localparam logic [7:0] ADDR_CTRL    = 8'(SR_SCHED_BASE + 2);
  localparam logic [7:0] ADDR_CLEAR   = 8'(SR_SCHED_BASE + 3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // A programmed weight of zero still grants one packet per turn.
  function automatic logic [7:0] eff_weight(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

  state_t      state;
  state_t      next_grant;
  logic [7:0]  credit;
  logic        in_pkt;
  logic        last_served;
  logic [7:0]  weight0;
  logic [7:0]  weight1;
  logic        enable;
  logic        strict_prio0;
  logic        rst_sync_p0;
  logic        rst_sync_p1;
  logic        rst_int_n;
  logic        hs;
  logic        hs_last;
  logic        decision;
  logic        cur_port;
  logic        own_valid;
  logic        other_valid;
  logic        p0_hold;
  logic [7:0]  own_weight;
  logic [7:0]  other_weight;
  logic        cnt_clear;
  logic        unused_set_data;

  assign unused_set_data = ^set_data[31:8];

  // Reset is asserted asynchronously and released on a ce_clk edge.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      rst_sync_p0 <= 1'b0;
      rst_sync_p1 <= 1'b0;
    end else begin
      rst_sync_p0 <= 1'b1;
      rst_sync_p1 <= rst_sync_p0;
    end
  end

  assign rst_int_n = rst_sync_p1;

  // Settings-bus registers: weights, enable and strict port-0 priority.
  always_ff @(posedge ce_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      weight0      <= 8'd1;
      weight1      <= 8'd1;
      enable       <= 1'b1;
      strict_prio0 <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == ADDR_WEIGHT0) weight0 <= set_data[7:0];
      if (set_addr == ADDR_WEIGHT1) weight1 <= set_data[7:0];
      if (set_addr == ADDR_CTRL) begin
        enable       <= set_data[0];
        strict_prio0 <= set_data[1];
      end
    end
  end

  assign cnt_clear = set_stb && (set_addr == ADDR_CLEAR);

  // Zero-latency mux from the granted requester; everything is 0 in IDLE.
  always_comb begin
    o_tdata   = '0;
    o_tuser   = '0;
    o_tlast   = 1'b0;
    o_tvalid  = 1'b0;
    i0_tready = 1'b0;
    i1_tready = 1'b0;
    unique case (state)
      GRANT0: begin
        o_tdata   = i0_tdata;
        o_tuser   = i0_tuser;
        o_tlast   = i0_tlast;
        o_tvalid  = i0_tvalid;
        i0_tready = o_tready;
      end
      GRANT1: begin
        o_tdata   = i1_tdata;
        o_tuser   = i1_tuser;
        o_tlast   = i1_tlast;
        o_tvalid  = i1_tvalid;
        i1_tready = o_tready;
      end
      default: ;
    endcase
  end

  assign hs           = o_tvalid & o_tready;
  assign hs_last      = hs & o_tlast;
  assign decision     = !in_pkt && !hs;
  assign busy         = in_pkt | hs;
  assign cur_port     = (state == GRANT1);
  assign active_port  = cur_port;
  assign own_valid    = cur_port ? i1_tvalid : i0_tvalid;
  assign other_valid  = cur_port ? i0_tvalid : i1_tvalid;
  assign own_weight   = cur_port ? weight1 : weight0;
  assign other_weight = cur_port ? weight0 : weight1;
  assign next_grant   = cur_port ? GRANT0 : GRANT1;
  // Under strict priority port 0 keeps the grant while it still has data.
  assign p0_hold      = strict_prio0 && !cur_port && i0_tvalid;

  // Grant FSM: decisions only at packet boundaries, never mid-packet.
  always_ff @(posedge ce_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      credit      <= 8'd0;
      in_pkt      <= 1'b0;
      last_served <= 1'b1;
    end else begin
      if (hs) in_pkt <= ~o_tlast;
      unique case (state)
        IDLE: begin
          if (enable) begin
            if (i0_tvalid && (strict_prio0 || !i1_tvalid || last_served)) begin
              state  <= GRANT0;
              credit <= eff_weight(weight0);
            end else if (i1_tvalid) begin
              state  <= GRANT1;
              credit <= eff_weight(weight1);
            end
          end
        end
        GRANT0, GRANT1: begin
          if (hs_last) begin
            last_served <= cur_port;
            if (!enable) begin
              state <= IDLE;
            end else if (strict_prio0 && cur_port && i0_tvalid) begin
              state  <= GRANT0;
              credit <= eff_weight(weight0);
            end else if (credit > 8'd1) begin
              credit <= credit - 8'd1;
            end else if (other_valid && !p0_hold) begin
              state  <= next_grant;
              credit <= eff_weight(other_weight);
            end else if (own_valid) begin
              credit <= eff_weight(own_weight);
            end else begin
              state <= IDLE;
            end
          end else if (decision && !own_valid) begin
            // Own requester went quiet between packets: hand over if possible.
            if (!enable) begin
              state <= IDLE;
            end else if (other_valid) begin
              state  <= next_grant;
              credit <= eff_weight(other_weight);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port packet counters; a clear write wins over a same-cycle increment.
  always_ff @(posedge ce_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (cnt_clear) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (hs_last) begin
      if (cur_port) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      else          pkt_cnt0 <= pkt_cnt0 + 32'd1;
    end
  end

endmodule
